// File: rtl/cpu_bus_timing_pkg.sv
// Shared definitions for the CPU bus timing generator: phase counter width,
// bus-cycle state encoding and the address windows that need a stretched cycle.
package cpu_bus_timing_pkg;

   localparam int PHASE_W = 5;
   localparam logic [PHASE_W-1:0] CNT_MAX   = 5'd31;
   localparam logic [3:0]         NOM_PHASE = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      ACCESS = 2'd2
   } bus_state_t;

   // FC00-FDFF: whole 512-byte page pair is slow
   localparam logic [15:0] SLOW_FC_BASE = 16'hFC00;
   localparam logic [15:0] SLOW_FC_MASK = 16'hFE00;
   // FE00-FEFF: slow, except for the hole below
   localparam logic [15:0] SLOW_FE_BASE = 16'hFE00;
   localparam logic [15:0] SLOW_FE_MASK = 16'hFF00;
   // FE20-FE3F: on-board fast peripherals inside the FE page
   localparam logic [15:0] FAST_HOLE_BASE = 16'hFE20;
   localparam logic [15:0] FAST_HOLE_MASK = 16'hFFE0;

   function automatic logic in_region(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/cpu_bus_timing_slow_addr_decode.sv
// Combinational decode of the CPU address into "needs a 1 MHz stretched cycle".
module slow_addr_decode
   import cpu_bus_timing_pkg::*;
(
   input  logic [15:0] ADDRESS,
   output logic        slow
);

   logic in_fc;
   logic in_fe;
   logic in_hole;

   assign in_fc   = in_region(ADDRESS, SLOW_FC_BASE, SLOW_FC_MASK);
   assign in_fe   = in_region(ADDRESS, SLOW_FE_BASE, SLOW_FE_MASK);
   assign in_hole = in_region(ADDRESS, FAST_HOLE_BASE, FAST_HOLE_MASK);

   // FC/FD pages are always slow; FE page is slow outside the fast hole
   assign slow = in_fc | (in_fe & ~in_hole);

endmodule

// File: rtl/cpu_bus_timing.sv
// CPU bus timing generator: derives the 2 MHz CPU enable and 1 MHz peripheral
// enable from a 32 MHz clock and stretches accesses to slow devices so they
// line up with the 1 MHz bus.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | normal 2 MHz operation, CPU_en at every unheld nominal point
//   SYNC   | slow access started mid 1 MHz period, waiting for cnt==31
//   ACCESS | slow access aligned to the 1 MHz bus, completes at cnt==31
module cpu_bus_timing
   import cpu_bus_timing_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] ADDRESS,
   input  logic        RnW,
   input  logic        HOLD,
   output logic        CPU_en,
   output logic        PHI1M_en,
   output logic        SLOW_ACC,
   output logic        DEV_STROBE,
   output logic        DEV_RnW
);

   logic [PHASE_W-1:0] cnt;
   bus_state_t         state;
   logic               slow;
   logic               nominal;
   logic               at_end;

   slow_addr_decode u_slow_addr_decode (
      .ADDRESS (ADDRESS),
      .slow    (slow)
   );

   assign at_end  = (cnt == CNT_MAX);
   assign nominal = (cnt[3:0] == NOM_PHASE);

   // Free-running phase counter, one full 1 MHz period per wrap
   always_ff @(posedge CLK) begin
      if (RESET) cnt <= '0;
      else       cnt <= cnt + PHASE_W'(1);
   end

   // Bus-cycle state machine; the address is only looked at in IDLE because
   // the CPU bus is frozen while a stretched cycle is pending
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         DEV_RnW <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (nominal && !HOLD && slow) begin
                  DEV_RnW <= RnW;
                  state   <= at_end ? ACCESS : SYNC;
               end
            end
            SYNC: begin
               if (at_end) state <= ACCESS;
            end
            ACCESS: begin
               if (at_end && !HOLD) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Enables must fire in the same CLK as the phase/address that qualifies
   // them, so they are decoded from the registered state rather than stored
   always_comb begin
      CPU_en     = 1'b0;
      DEV_STROBE = 1'b0;
      if (!RESET) begin
         case (state)
            IDLE:    CPU_en = nominal && !HOLD && !slow;
            ACCESS: begin
               if (at_end && !HOLD) begin
                  CPU_en     = 1'b1;
                  DEV_STROBE = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign PHI1M_en = !RESET && at_end;
   assign SLOW_ACC = !RESET && (state != IDLE);

endmodule

// File: tb/tb_cpu_bus_timing.sv
// Directed bench for cpu_bus_timing. ph is the CLK index since reset release;
// ph==0 is the first CLK with cnt==0, so the DUT phase is ph mod 32.
module tb_cpu_bus_timing;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] ADDRESS;
   logic        RnW;
   logic        HOLD;
   logic        CPU_en;
   logic        PHI1M_en;
   logic        SLOW_ACC;
   logic        DEV_STROBE;
   logic        DEV_RnW;

   int   ph;
   int   n_pass;
   int   n_total;
   int   slow_cnt;
   int   cpu_q[$];
   int   str_q[$];
   int   phi_q[$];
   int   exp_q[$];
   logic s_cpu, s_phi, s_slow, s_str;

   cpu_bus_timing dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .ADDRESS    (ADDRESS),
      .RnW        (RnW),
      .HOLD       (HOLD),
      .CPU_en     (CPU_en),
      .PHI1M_en   (PHI1M_en),
      .SLOW_ACC   (SLOW_ACC),
      .DEV_STROBE (DEV_STROBE),
      .DEV_RnW    (DEV_RnW)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // sel: 0 = CPU_en events, 1 = DEV_STROBE events, 2 = PHI1M_en events
   task automatic chk_q(input string tag, input int sel);
      int got[$];
      case (sel)
         0:       got = cpu_q;
         1:       got = str_q;
         default: got = phi_q;
      endcase
      chk({tag, ".count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
   endtask

   task automatic clear_log();
      cpu_q.delete();
      str_q.delete();
      phi_q.delete();
      slow_cnt = 0;
   endtask

   // Called at a falling edge with inputs settled; samples just before the
   // rising edge, logs events against ph, returns at the next falling edge
   task automatic clk1();
      #4;
      s_cpu  = CPU_en;
      s_phi  = PHI1M_en;
      s_slow = SLOW_ACC;
      s_str  = DEV_STROBE;
      if (s_cpu === 1'b1) cpu_q.push_back(ph);
      if (s_str === 1'b1) str_q.push_back(ph);
      if (s_phi === 1'b1) phi_q.push_back(ph);
      if (s_slow === 1'b1) slow_cnt++;
      @(negedge CLK);
      ph++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) clk1();
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      ph      = 0;
      RESET   = 1'b1;
      ADDRESS = 16'hC000;
      RnW     = 1'b1;
      HOLD    = 1'b0;
      clear_log();
      @(negedge CLK);

      // Reset state
      run(3);
      chk("rst.CPU_en",     s_cpu,  1'b0);
      chk("rst.PHI1M_en",   s_phi,  1'b0);
      chk("rst.SLOW_ACC",   s_slow, 1'b0);
      chk("rst.DEV_STROBE", s_str,  1'b0);
      chk("rst.DEV_RnW",    DEV_RnW, 1'b1);

      // Fast cycles after release
      RESET = 1'b0;
      ph    = 0;
      clear_log();
      run(64);                                  // ph 0..63
      exp_q = '{15, 31, 47, 63};  chk_q("fast.cpu", 0);
      exp_q = '{31, 63};          chk_q("fast.phi", 2);
      exp_q = '{};                chk_q("fast.str", 1);
      chk("fast.slow_cnt", slow_cnt, 0);

      // FE40 write presented at cnt==15: 48 CLK stretch via SYNC
      clear_log();
      run(15);                                  // ph 64..78
      ADDRESS = 16'hFE40;
      RnW     = 1'b0;
      run(49);                                  // ph 79..127
      exp_q = '{127};             chk_q("fe40.cpu", 0);
      exp_q = '{127};             chk_q("fe40.str", 1);
      exp_q = '{95, 127};         chk_q("fe40.phi", 2);
      chk("fe40.slow_cnt", slow_cnt, 48);
      chk("fe40.DEV_RnW", DEV_RnW, 1'b0);
      ADDRESS = 16'hC000;
      RnW     = 1'b1;

      // FC10 read presented at cnt==31: 32 CLK stretch straight to ACCESS
      clear_log();
      run(31);                                  // ph 128..158
      ADDRESS = 16'hFC10;
      run(33);                                  // ph 159..191
      exp_q = '{143, 191};        chk_q("fc10.cpu", 0);
      exp_q = '{191};             chk_q("fc10.str", 1);
      chk("fc10.slow_cnt", slow_cnt, 32);
      chk("fc10.DEV_RnW", DEV_RnW, 1'b1);
      ADDRESS = 16'hC000;

      // FE30 lies in the fast hole
      clear_log();
      run(15);                                  // ph 192..206
      ADDRESS = 16'hFE30;
      run(32);                                  // ph 207..238
      exp_q = '{207, 223};        chk_q("fe30.cpu", 0);
      exp_q = '{};                chk_q("fe30.str", 1);
      chk("fe30.slow_cnt", slow_cnt, 0);

      // FEFF is slow; ph 239 is cnt==15 so completion lands 48 CLK later
      clear_log();
      ADDRESS = 16'hFEFF;
      run(49);                                  // ph 239..287
      exp_q = '{287};             chk_q("feff.cpu", 0);
      exp_q = '{287};             chk_q("feff.str", 1);
      chk("feff.slow_cnt", slow_cnt, 48);
      ADDRESS = 16'hC000;

      // HOLD for 40 CLK in IDLE
      clear_log();
      HOLD = 1'b1;
      run(40);                                  // ph 288..327
      exp_q = '{};                chk_q("hold.cpu", 0);
      exp_q = '{319};             chk_q("hold.phi", 2);
      HOLD = 1'b0;
      clear_log();
      run(23);                                  // ph 328..350
      exp_q = '{335};             chk_q("unhold.cpu", 0);

      // FD00 at cnt==31 with HOLD over the first completion point (ph 383)
      clear_log();
      ADDRESS = 16'hFD00;
      run(25);                                  // ph 351..375
      HOLD = 1'b1;
      run(12);                                  // ph 376..387
      HOLD = 1'b0;
      run(28);                                  // ph 388..415
      exp_q = '{415};             chk_q("hacc.cpu", 0);
      exp_q = '{415};             chk_q("hacc.str", 1);
      exp_q = '{351, 383, 415};   chk_q("hacc.phi", 2);
      chk("hacc.slow_cnt", slow_cnt, 64);
      ADDRESS = 16'hC000;

      // RESET in the middle of an FD00 access
      clear_log();
      run(31);                                  // ph 416..446
      ADDRESS = 16'hFD00;
      run(10);                                  // ph 447..456
      chk("abort.in_access", s_slow, 1'b1);
      exp_q = '{431};             chk_q("abort.pre_cpu", 0);
      clear_log();
      RESET = 1'b1;
      run(2);
      chk("abort.rst_slow", s_slow, 1'b0);
      chk("abort.rst_cpu",  s_cpu,  1'b0);
      exp_q = '{};                chk_q("abort.rst_str", 1);
      RESET   = 1'b0;
      ADDRESS = 16'hC000;
      ph      = 0;
      clear_log();
      run(32);                                  // ph 0..31
      exp_q = '{15, 31};          chk_q("abort.cpu", 0);
      exp_q = '{};                chk_q("abort.str", 1);
      chk("abort.slow_cnt", slow_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_bus_timing.md
CPU_BUS_TIMING -- requirements
Module: cpu_bus_timing

Interface
REQ-001 SHALL have port CLK, input, 1 bit: system clock, 16x the nominal 2 MHz CPU rate.
REQ-002 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ADDRESS, input, 16 bits: CPU address bus.
REQ-004 SHALL have port RnW, input, 1 bit: CPU read/not-write, passed through unused except in DEV_RnW.
REQ-005 SHALL have port HOLD, input, 1 bit: freeze request; suppresses CPU_en.
REQ-006 SHALL have port CPU_en, output, 1 bit: one-CLK enable that drives the MOS6502 CLK_en.
REQ-007 SHALL have port PHI1M_en, output, 1 bit: 1 MHz peripheral enable, one CLK every 32.
REQ-008 SHALL have port SLOW_ACC, output, 1 bit: high while a stretched cycle is in progress.
REQ-009 SHALL have port DEV_STROBE, output, 1 bit: one-CLK pulse at completion of a slow access.
REQ-010 SHALL have port DEV_RnW, output, 1 bit: RnW captured at slow-access start.

Function
REQ-011 SHALL keep a free-running 5-bit phase counter cnt, +1 per CLK, wrapping 31->0.
REQ-012 SHALL assert PHI1M_en combinationally when cnt==31, regardless of state or HOLD.
REQ-013 SHALL define nominal points as cnt[3:0]==15, i.e. cnt==15 or cnt==31.
REQ-014 SHALL decode slow as: ADDRESS[15:9]==7'b1111110 (FC00-FDFF), or ADDRESS[15:8]==8'hFE with ADDRESS[7:5]!=3'b001 (FE20-FE3F excluded).
REQ-015 SHALL use state machine states IDLE, SYNC and ACCESS.
REQ-016 IDLE, nominal point, HOLD=0, not slow: SHALL assert CPU_en for that CLK.
REQ-017 IDLE, nominal point, HOLD=1: SHALL keep CPU_en low; cycle skipped; state stays IDLE.
REQ-018 IDLE, nominal point, HOLD=0, slow, cnt==15: SHALL suppress CPU_en, capture DEV_RnW, and go to SYNC.
REQ-019 IDLE, nominal point, HOLD=0, slow, cnt==31: SHALL suppress CPU_en, capture DEV_RnW, and go to ACCESS.
REQ-020 SYNC, cnt==31: SHALL go to ACCESS with no CPU_en.
REQ-021 ACCESS, cnt==31, HOLD=0: SHALL assert CPU_en and DEV_STROBE for that CLK and return to IDLE.
REQ-022 ACCESS, cnt==31, HOLD=1: SHALL stay in ACCESS; completion deferred by 32 CLK.
REQ-023 Cycle lengths SHALL be: fast cycle 16 CLK; slow cycle starting at cnt==15 totals 48 CLK (3 CPU cycles); slow cycle starting at cnt==31 totals 32 CLK (2 CPU cycles).
REQ-024 SLOW_ACC SHALL be high whenever state is SYNC or ACCESS.
REQ-025 SHALL ignore ADDRESS changes during SYNC/ACCESS, since the CPU bus is frozen while CPU_en is low.
REQ-026 CPU_en and DEV_STROBE SHALL never be high in the same CLK except at slow completion.
REQ-027 CPU_en SHALL never assert at a non-nominal cnt.

Reset
REQ-028 While RESET=1 at a CLK edge: cnt:=0, state:=IDLE, DEV_RnW:=1.
REQ-029 While RESET=1: CPU_en, PHI1M_en, SLOW_ACC and DEV_STROBE SHALL be 0.
REQ-030 RESET asserted mid-stretch SHALL abort the access with no DEV_STROBE.
REQ-031 After RESET deasserts, the first CPU_en SHALL occur 16 CLK later (cnt==15).

Structure
REQ-032 A shared package SHALL hold: state enum {IDLE,SYNC,ACCESS}; slow-region base/mask constants (FC00/FE00); fast-hole FE20-FE3F constants; PHASE_W=5.
REQ-033 SHALL contain one sub-module, slow_addr_decode: purely combinational ADDRESS->slow.
REQ-034 Counter and FSM SHALL be in the top module.

Verification
REQ-035 Reset release, ADDRESS=16'hC000, HOLD=0 -> CPU_en at CLK 16,32,48,... after release; PHI1M_en at 32,64,...; SLOW_ACC stays 0.
REQ-036 ADDRESS=16'hFE40 presented at cnt==15 -> no CPU_en at cnt 15 or 31; CPU_en+DEV_STROBE at following cnt==31 (48 CLK later); SLOW_ACC high for 48 CLK.
REQ-037 ADDRESS=16'hFC10 presented at cnt==31 -> CPU_en+DEV_STROBE exactly 32 CLK later.
REQ-038 ADDRESS=16'hFE30 and 16'hFEFF -> FE30 fast (16 CLK); FEFF stretched.
REQ-039 HOLD=1 for 40 CLK in IDLE, then during ACCESS at completion -> no CPU_en while held; completion slips 32 CLK; PHI1M_en unaffected.
REQ-040 RESET pulsed mid-ACCESS with ADDRESS=16'hFD00 -> no DEV_STROBE; first CPU_en 16 CLK after release; state IDLE.
